imem_load_ctrl: RTL and testbench

//  Boot sequencer and read-port owner for the instruction BRAM (bram32) and PC.

---
 rtl/imem_load_ctrl_pkg.sv | 30 +++
 rtl/imem_load_ctrl_if.sv | 39 +++
 rtl/imem_load_ctrl_rd_mux.sv | 24 ++
 rtl/imem_load_ctrl.sv | 174 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: IMEM_VERIFY_EN (read-back verification of the loaded program).
package imem_load_ctrl_pkg;

   localparam int LDC_DATA_WIDTH = 32;
   localparam int LDC_ADDR_WIDTH = 10;
   localparam int I_BRAM_DEPTH   = 256;

   typedef enum logic [2:0] {
      LDC_IDLE   = 3'd0,
      LDC_LOAD   = 3'd1,
      LDC_VERIFY = 3'd2,
      LDC_VDRAIN = 3'd3,
      LDC_LAUNCH = 3'd4,
      LDC_RUN    = 3'd5,
      LDC_ERROR  = 3'd6
   } ldc_state_t;

   typedef enum logic [1:0] {
      LDC_ERR_NONE   = 2'b00,
      LDC_ERR_COUNT  = 2'b01,
      LDC_ERR_VERIFY = 2'b10
   } ldc_err_t;

   // A program length is acceptable when it is non-zero and fits the I-BRAM.
   function automatic logic count_ok(input logic [8:0] wc, input int max_words);
      return (wc != 9'd0) && (int'({23'd0, wc}) <= max_words);
   endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the boot loader and its surroundings: program stream,
// BRAM write port, BRAM read port and the PC control/feedback lines.
// master = loader side, slave = stream source / BRAM / PC side.
interface imem_load_ctrl_if
   import imem_load_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = LDC_DATA_WIDTH,
   parameter int ADDR_WIDTH = LDC_ADDR_WIDTH
) ();

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   logic [ADDR_WIDTH-1:0] mem_w_addr;
   logic [DATA_WIDTH-1:0] mem_w_dat;
   logic                  mem_w_enb;

   logic [DATA_WIDTH-1:0] mem_r_addr;
   logic                  mem_r_enb;
   logic [DATA_WIDTH-1:0] mem_r_dat;

   logic [DATA_WIDTH-1:0] pc_in;
   logic                  pc_stall;
   logic                  pc_load;

   modport master (
      input  s_valid, s_data, mem_r_dat, pc_in,
      output s_ready, mem_w_addr, mem_w_dat, mem_w_enb,
             mem_r_addr, mem_r_enb, pc_stall, pc_load
   );

   modport slave (
      output s_valid, s_data, mem_r_dat, pc_in,
      input  s_ready, mem_w_addr, mem_w_dat, mem_w_enb,
             mem_r_addr, mem_r_enb, pc_stall, pc_load
   );

endinterface

// File: rtl/imem_load_ctrl_rd_mux.sv
// I-BRAM read-port arbiter: the running PC owns the port in LAUNCH/RUN, the
// verify walker owns it during read-back, otherwise the port is idle (addr 0).
module imem_load_ctrl_rd_mux #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  run_sel,
   input  logic                  ver_sel,
   input  logic [DATA_WIDTH-1:0] pc_addr,
   input  logic [DATA_WIDTH-1:0] ver_addr,
   output logic [DATA_WIDTH-1:0] r_addr,
   output logic                  r_enb
);

   logic ver_only;

   assign ver_only = ver_sel & ~run_sel;
   assign r_enb    = run_sel | ver_sel;

   // Per-bit AND-OR select; PC has priority, both deselected yields zero.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_addr_bit
      assign r_addr[gi] = (run_sel & pc_addr[gi]) | (ver_only & ver_addr[gi]);
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot sequencer for the instruction BRAM: stalls the PC, streams a program
// into I-BRAM over a valid/ready port, optionally verifies it by read-back
// (macro IMEM_VERIFY_EN), pulses a PC load and then hands the read port to
// the PC.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = LDC_DATA_WIDTH,
   parameter int ADDR_WIDTH = LDC_ADDR_WIDTH,
   parameter int MAX_WORDS  = I_BRAM_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  word_count,
   imem_load_ctrl_if.master bus,
   output logic        busy,
   output logic        running,
   output logic        err,
   output logic [1:0]  err_code
);

   ldc_state_t            state_reg;
   ldc_err_t              err_code_reg;
   logic [8:0]            count_reg;
   logic [8:0]            idx_reg;
   logic [DATA_WIDTH-1:0] csum_reg;
   logic                  s_ready_reg;
   logic                  mem_w_enb_reg;
   logic [ADDR_WIDTH-1:0] mem_w_addr_reg;
   logic [DATA_WIDTH-1:0] mem_w_dat_reg;
   logic                  pc_stall_reg;
   logic                  pc_load_reg;

   logic                  handshake;
   logic                  last_word;
   logic                  run_sel;
   logic                  ver_sel;
   logic [DATA_WIDTH-1:0] ver_addr;

   assign handshake = bus.s_valid & s_ready_reg;
   assign last_word = (idx_reg + 9'd1) == count_reg;
   assign run_sel   = (state_reg == LDC_LAUNCH) || (state_reg == LDC_RUN);

`ifdef IMEM_VERIFY_EN
   logic [8:0]            ridx_reg;
   logic [DATA_WIDTH-1:0] vsum_reg;

   assign ver_sel  = (state_reg == LDC_VERIFY);
   assign ver_addr = DATA_WIDTH'({ridx_reg, 2'b00});
`else
   logic unused_rd_dat;

   assign ver_sel       = 1'b0;
   assign ver_addr      = '0;
   assign unused_rd_dat = ^bus.mem_r_dat;
`endif

   // Boot FSM with its word counter, checksum and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= LDC_IDLE;
         err_code_reg   <= LDC_ERR_NONE;
         count_reg      <= '0;
         idx_reg        <= '0;
         csum_reg       <= '0;
         s_ready_reg    <= 1'b0;
         mem_w_enb_reg  <= 1'b0;
         mem_w_addr_reg <= '0;
         mem_w_dat_reg  <= '0;
         pc_stall_reg   <= 1'b1;
         pc_load_reg    <= 1'b0;
`ifdef IMEM_VERIFY_EN
         ridx_reg       <= '0;
         vsum_reg       <= '0;
`endif
      end else begin
         mem_w_enb_reg <= 1'b0;
         pc_load_reg   <= 1'b0;
         case (state_reg)
            LDC_IDLE, LDC_RUN, LDC_ERROR: begin
               if (start) begin
                  pc_stall_reg <= 1'b1;
                  if (!count_ok(word_count, MAX_WORDS)) begin
                     state_reg    <= LDC_ERROR;
                     err_code_reg <= LDC_ERR_COUNT;
                  end else begin
                     state_reg    <= LDC_LOAD;
                     err_code_reg <= LDC_ERR_NONE;
                     count_reg    <= word_count;
                     idx_reg      <= '0;
                     csum_reg     <= '0;
                     s_ready_reg  <= 1'b1;
                  end
               end
            end
            LDC_LOAD: begin
               if (handshake) begin
                  mem_w_enb_reg  <= 1'b1;
                  mem_w_addr_reg <= ADDR_WIDTH'({idx_reg, 2'b00});
                  mem_w_dat_reg  <= bus.s_data;
                  csum_reg       <= csum_reg ^ bus.s_data;
                  idx_reg        <= idx_reg + 9'd1;
                  if (last_word) begin
                     s_ready_reg <= 1'b0;
`ifdef IMEM_VERIFY_EN
                     state_reg   <= LDC_VERIFY;
                     ridx_reg    <= '0;
                     vsum_reg    <= '0;
`else
                     state_reg    <= LDC_LAUNCH;
                     pc_load_reg  <= 1'b1;
                     pc_stall_reg <= 1'b0;
`endif
                  end
               end
            end
`ifdef IMEM_VERIFY_EN
            LDC_VERIFY: begin
               // Read data lags the address by one cycle; nothing to fold in on the first one.
               if (ridx_reg != 9'd0) begin
                  vsum_reg <= vsum_reg ^ bus.mem_r_dat;
               end
               ridx_reg <= ridx_reg + 9'd1;
               if ((ridx_reg + 9'd1) == count_reg) begin
                  state_reg <= LDC_VDRAIN;
               end
            end
            LDC_VDRAIN: begin
               if ((vsum_reg ^ bus.mem_r_dat) == csum_reg) begin
                  state_reg    <= LDC_LAUNCH;
                  pc_load_reg  <= 1'b1;
                  pc_stall_reg <= 1'b0;
               end else begin
                  state_reg    <= LDC_ERROR;
                  err_code_reg <= LDC_ERR_VERIFY;
               end
            end
`endif
            LDC_LAUNCH: begin
               state_reg <= LDC_RUN;
            end
            default: begin
               state_reg <= LDC_IDLE;
            end
         endcase
      end
   end

   imem_load_ctrl_rd_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_mux (
      .run_sel  (run_sel),
      .ver_sel  (ver_sel),
      .pc_addr  (bus.pc_in),
      .ver_addr (ver_addr),
      .r_addr   (bus.mem_r_addr),
      .r_enb    (bus.mem_r_enb)
   );

   assign bus.s_ready    = s_ready_reg;
   assign bus.mem_w_enb  = mem_w_enb_reg;
   assign bus.mem_w_addr = mem_w_addr_reg;
   assign bus.mem_w_dat  = mem_w_dat_reg;
   assign bus.pc_stall   = pc_stall_reg;
   assign bus.pc_load    = pc_load_reg;

   assign busy     = (state_reg == LDC_LOAD) || (state_reg == LDC_VERIFY) ||
                     (state_reg == LDC_VDRAIN) || (state_reg == LDC_LAUNCH);
   assign running  = (state_reg == LDC_RUN);
   assign err      = (state_reg == LDC_ERROR);
   assign err_code = err_code_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a behavioural I-BRAM and PC.
`timescale 1ns/1ps
module tb_imem_load_ctrl;

   localparam int DW   = 32;
   localparam int AW   = 10;
   localparam int MAXW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [8:0]    word_count = '0;
   logic          busy, running, err;
   logic [1:0]    err_code;
   logic          flip_req = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] prog [0:255];
   logic [DW-1:0] bram [0:255];
   logic [DW-1:0] pc;

   imem_load_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   imem_load_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_WORDS  (MAXW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .running    (running),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Behavioural write-first BRAM with registered read, plus a simple PC (boot address 0).
   always @(posedge clk) begin
      if (bus.mem_w_enb) bram[bus.mem_w_addr[AW-1:2]] <= bus.mem_w_dat;
      if (flip_req) bram[2] <= bram[2] ^ 32'h1;
      if (bus.mem_r_enb)
         bus.mem_r_dat <= (bus.mem_w_enb && bus.mem_w_addr[AW-1:2] == bus.mem_r_addr[AW-1:2]) ?
                          bus.mem_w_dat : bram[bus.mem_r_addr[AW-1:2]];
      if (rst)               pc <= 32'h40;
      else if (bus.pc_load)  pc <= 32'h0;
      else if (!bus.pc_stall) pc <= pc + 32'd4;
   end
   assign bus.pc_in = pc;

   // Full load transaction: start, stream n words (valid pattern by mode), launch, first fetch.
   task automatic run_load(input int n, input int mode);
      int   sent;
      int   cyc;
      logic v;
      start = 1'b1; word_count = 9'(n); bus.s_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if ({bus.s_ready, bus.pc_stall, busy, running, err, bus.mem_r_enb} !== 6'b111000) begin
         bad++;
         $display("FAIL load_entry n=%0d got=%b exp=111000", n,
                  {bus.s_ready, bus.pc_stall, busy, running, err, bus.mem_r_enb});
      end
      sent = 0; cyc = 0;
      while (sent < n && cyc < 8*n + 50) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.s_valid = v;
         bus.s_data  = v ? prog[sent] : $urandom;
         total++;
         if (bus.s_ready !== 1'b1) begin
            bad++; $display("FAIL s_ready_load word=%0d got=%b exp=1", sent, bus.s_ready);
         end
         @(posedge clk); #1;
         cyc++;
         if (v) begin
            sent++;
            total++;
            if ({bus.mem_w_enb, bus.mem_w_addr, bus.mem_w_dat} !== {1'b1, AW'((sent-1)*4), prog[sent-1]}) begin
               bad++;
               $display("FAIL write word=%0d got=%b/%h/%h exp=1/%h/%h", sent-1, bus.mem_w_enb,
                        bus.mem_w_addr, bus.mem_w_dat, AW'((sent-1)*4), prog[sent-1]);
            end
         end else begin
            total++;
            if (bus.mem_w_enb !== 1'b0) begin
               bad++; $display("FAIL idle_write cyc=%0d got=%b exp=0", cyc, bus.mem_w_enb);
            end
         end
      end
      total++;
      if (sent != n) begin
         bad++; $display("FAIL load_timeout got=%0d exp=%0d", sent, n);
      end
      // Stray traffic after the last word must be refused.
      bus.s_valid = 1'b1; bus.s_data = $urandom;
`ifdef IMEM_VERIFY_EN
      for (int k = 0; k < n + 1; k++) begin
         total++;
         if ({bus.pc_load, bus.pc_stall, busy, bus.s_ready} !== 4'b0110) begin
            bad++; $display("FAIL verify_wait k=%0d got=%b exp=0110", k,
                            {bus.pc_load, bus.pc_stall, busy, bus.s_ready});
         end
         @(posedge clk); #1;
      end
`endif
      total++;
      if ({bus.pc_load, bus.pc_stall, bus.s_ready, busy, bus.mem_r_enb} !== 5'b10011) begin
         bad++; $display("FAIL launch got=%b exp=10011",
                         {bus.pc_load, bus.pc_stall, bus.s_ready, busy, bus.mem_r_enb});
      end
      @(posedge clk); #1;
      total++;
      if ({bus.pc_load, bus.pc_stall, running, busy, bus.mem_r_enb, bus.mem_w_enb, bus.s_ready, err_code} !== 9'b001010000) begin
         bad++; $display("FAIL run_entry got=%b exp=001010000",
                         {bus.pc_load, bus.pc_stall, running, busy, bus.mem_r_enb, bus.mem_w_enb, bus.s_ready, err_code});
      end
      total++;
      if (bus.mem_r_addr !== 32'h0) begin
         bad++; $display("FAIL boot_addr got=%h exp=0", bus.mem_r_addr);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.mem_r_addr, bus.mem_r_dat} !== {32'h4, prog[0]}) begin
         bad++; $display("FAIL first_instr got=%h/%h exp=4/%h", bus.mem_r_addr, bus.mem_r_dat, prog[0]);
      end
      total++;
      if (bus.mem_w_enb !== 1'b0) begin
         bad++; $display("FAIL stray_write got=%b exp=0", bus.mem_w_enb);
      end
      bus.s_valid = 1'b0;
      $display("load n=%0d mode=%0d stream_cycles=%0d", n, mode, cyc);
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b0; bus.s_data = '0; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.s_ready, bus.mem_w_enb, bus.mem_r_enb, bus.pc_stall, bus.pc_load, busy, running, err, err_code} !== 10'b0001000000) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0001000000",
                         {bus.s_ready, bus.mem_w_enb, bus.mem_r_enb, bus.pc_stall, bus.pc_load, busy, running, err, err_code});
      end
      total++;
      if ({bus.mem_w_addr, bus.mem_w_dat, bus.mem_r_addr} !== '0) begin
         bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.mem_w_addr, bus.mem_w_dat, bus.mem_r_addr);
      end
      rst = 1'b0;
      $display("reset done");
   endtask

   task automatic test_basic_load();
      prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
      prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
      run_load(4, 0);
   endtask

   task automatic test_gapped_valid();
      for (int i = 0; i < 4; i++) prog[i] = $urandom;
      run_load(4, 1);
   endtask

   task automatic test_bad_count();
      logic [8:0] bad_counts [2];
      bad_counts[0] = 9'd0; bad_counts[1] = 9'd257;
      for (int i = 0; i < 2; i++) begin
         start = 1'b1; word_count = bad_counts[i];
         @(posedge clk); #1;
         start = 1'b0;
         total++;
         if ({err, err_code, bus.pc_stall, busy, bus.s_ready, bus.mem_r_enb} !== 7'b1011000) begin
            bad++; $display("FAIL bad_count cnt=%0d got=%b exp=1011000", bad_counts[i],
                            {err, err_code, bus.pc_stall, busy, bus.s_ready, bus.mem_r_enb});
         end
         $display("start cnt=%0d err=%b code=%b", bad_counts[i], err, err_code);
      end
      for (int i = 0; i < 2; i++) prog[i] = $urandom;
      run_load(2, 2);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) prog[i] = $urandom;
      start = 1'b1; word_count = 9'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.s_valid = 1'b1; bus.s_data = prog[i];
         @(posedge clk); #1;
      end
      rst = 1'b1; bus.s_data = prog[2];
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({bus.s_ready, bus.pc_stall, busy, running, err, bus.mem_w_enb} !== 6'b010000) begin
         bad++; $display("FAIL mid_reset got=%b exp=010000",
                         {bus.s_ready, bus.pc_stall, busy, running, err, bus.mem_w_enb});
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         total++;
         if ({bus.mem_w_enb, bus.s_ready, bus.pc_stall} !== 3'b001) begin
            bad++; $display("FAIL post_reset k=%0d got=%b exp=001", k, {bus.mem_w_enb, bus.s_ready, bus.pc_stall});
         end
      end
      total++;
      if ({bram[0], bram[1]} !== {prog[0], prog[1]}) begin
         bad++; $display("FAIL partial_kept got=%h/%h exp=%h/%h", bram[0], bram[1], prog[0], prog[1]);
      end
      bus.s_valid = 1'b0;
      $display("mid-load reset after 2 words");
   endtask

   task automatic test_restart();
      for (int i = 0; i < 3; i++) prog[i] = $urandom;
      run_load(3, 2);
      prog[0] = $urandom;
      run_load(1, 0);
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 3; t++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) prog[i] = $urandom;
         run_load(n, 2);
      end
      for (int i = 0; i < MAXW; i++) prog[i] = $urandom;
      run_load(MAXW, 0);
   endtask

`ifdef IMEM_VERIFY_EN
   task automatic test_verify_corrupt();
      int plc = 0;
      for (int i = 0; i < 4; i++) prog[i] = $urandom;
      start = 1'b1; word_count = 9'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'b1; bus.s_data = prog[i];
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0; flip_req = 1'b1;
      @(posedge clk); #1;
      flip_req = 1'b0;
      plc += int'(bus.pc_load);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         plc += int'(bus.pc_load);
      end
      total++;
      if ({err, err_code, bus.pc_stall} !== 4'b1101 || plc != 0) begin
         bad++; $display("FAIL verify_corrupt got=%b loads=%0d exp=1101 loads=0",
                         {err, err_code, bus.pc_stall}, plc);
      end
      $display("verify corrupt err=%b code=%b", err, err_code);
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_gapped_valid();
      test_bad_count();
      test_reset_mid();
      test_restart();
      test_random();
`ifdef IMEM_VERIFY_EN
      test_verify_corrupt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
